// File: rtl/popcount_tnn_pkg.sv
// popcount_tnn_pkg: shared state type and sizing helpers for the serial popcount unit
package popcount_tnn_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic int calc_nb(input int n, input int c);
    return (n + c - 1) / c;
  endfunction
  function automatic int calc_outw(input int n);
    return $clog2(n + 1);
  endfunction
  // ones mark the low input bits discarded in approximate mode
  function automatic logic [255:0] drop_mask(input int drop);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < drop; i++) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: combinational population count of one CHUNK-bit slice
module popcount_chunk #(
  parameter int CHUNK = 8,
  localparam int CW = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [CW-1:0]    count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/popcount_tnn_serial.sv
// popcount_tnn_serial: multi-cycle popcount reducing CHUNK bits per beat with threshold activation
module popcount_tnn_serial
  import popcount_tnn_pkg::*;
#(
  parameter int N_IN = 29,
  parameter int CHUNK = 8,
  parameter int APPROX_DROP = 4,
  localparam int OUT_W = calc_outw(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_approx,
  input  logic [OUT_W-1:0] in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_count,
  output logic             out_act,
  output logic             busy
);
  localparam int NB = calc_nb(N_IN, CHUNK);
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int CW = $clog2(CHUNK + 1);
  localparam logic [255:0] DMASK = drop_mask(APPROX_DROP);
  state_t state;
  logic [N_IN-1:0] vec_r;
  logic [OUT_W-1:0] thr_r, acc, sum;
  logic [IW-1:0] idx;
  logic [NB*CHUNK-1:0] padded;
  logic [CHUNK-1:0] slice;
  logic [CW-1:0] cnt;
  // last chunk is zero-padded so the indexed slice never reads past the vector
  always_comb begin
    padded = '0;
    padded[N_IN-1:0] = vec_r;
    slice = padded[idx*CHUNK +: CHUNK];
  end
  popcount_chunk #(.CHUNK(CHUNK)) u_chunk (.bits(slice), .count(cnt));
  assign sum = acc + OUT_W'(cnt);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      vec_r <= '0;
      thr_r <= '0;
      acc <= '0;
      idx <= '0;
      out_count <= '0;
      out_act <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          vec_r <= in_approx ? in_vec & ~DMASK[N_IN-1:0] : in_vec;
          thr_r <= in_thresh;
          acc <= '0;
          idx <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= sum;
          idx <= idx + IW'(1);
          if (idx == IW'(NB - 1)) begin
            out_count <= sum;
            out_act <= sum >= thr_r;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_popcount_tnn_serial.sv
// tb_popcount_tnn_serial: directed checks of the serial popcount against a cycle-level reference model
module tb_popcount_tnn_serial;
  localparam int NB = 4;
  localparam int CHS [3] = '{1, 7, 29};
  localparam int NBS [3] = '{29, 5, 1};
  logic clk, rst, in_valid, in_ready, in_approx, out_valid, out_ready, out_act, busy;
  logic [28:0] in_vec;
  logic [4:0] in_thresh, out_count;
  logic sw_valid, sw_approx, sw_oready;
  logic [28:0] sw_vec;
  logic [4:0] sw_thr;
  logic sw_rdy [3], sw_ov [3], sw_act [3], sw_busy [3];
  logic [4:0] sw_cnt [3];
  int checks = 0, errors = 0;
  popcount_tnn_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_approx(in_approx), .in_thresh(in_thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_act(out_act), .busy(busy)
  );
  for (genvar g = 0; g < 3; g++) begin : sweep
    popcount_tnn_serial #(.CHUNK(CHS[g])) u (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[g]), .in_vec(sw_vec),
      .in_approx(sw_approx), .in_thresh(sw_thr), .out_valid(sw_ov[g]), .out_ready(sw_oready),
      .out_count(sw_cnt[g]), .out_act(sw_act[g]), .busy(sw_busy[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int ref_count(input logic [28:0] v, input logic a);
    logic [28:0] m;
    m = v;
    if (a) for (int i = 0; i < 4; i++) m[i] = 1'b0;
    return $countones(m);
  endfunction
  // reference: request is answered NB cycles after acceptance, held until consumed
  logic m_ready, m_valid, m_act, p_act;
  int m_cnt, p_cnt, m_left;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_cnt <= 0;
      m_act <= 1'b0;
      m_left <= 0;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_cnt <= p_cnt;
        m_act <= p_act;
      end
    end else if (m_ready && in_valid) begin
      p_cnt <= ref_count(in_vec, in_approx);
      p_act <= ref_count(in_vec, in_approx) >= int'(in_thresh);
      m_left <= NB;
      m_ready <= 1'b0;
    end
  always @(negedge clk)
    if (rst === 1'b0) begin
      chk("in_ready", in_ready, m_ready);
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, !m_ready);
      chk("out_count", out_count, m_cnt);
      chk("out_act", out_act, m_act);
    end
  task automatic run(input logic [28:0] v, input logic a, input logic [4:0] t,
                     output int lat, output int low, output int cnt, output int act);
    @(negedge clk);
    in_valid = 1'b1; in_vec = v; in_approx = a; in_thresh = t;
    @(negedge clk);
    in_valid = 1'b0; in_vec = ~v; in_approx = ~a; in_thresh = ~t;
    lat = -1; low = 0; cnt = -1; act = -1;
    for (int k = 0; k < 40; k++) begin
      if (!in_ready) low++;
      if (out_valid && lat < 0) begin
        lat = k; cnt = int'(out_count); act = int'(out_act);
      end
      if (in_ready && lat >= 0) break;
      @(negedge clk);
    end
  endtask
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin lat = k; break; end
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, low, cnt, act;
    int lats [3], cnts [3], acts [3];
    logic [28:0] v;
    logic [4:0] t;
    bit all;
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_approx = 1'b0; in_thresh = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_approx = 1'b0; sw_oready = 1'b1; sw_vec = '0; sw_thr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_act", out_act, 0);
    chk("rst_busy", busy, 0);
    run(29'h0, 1'b0, 5'd1, lat, low, cnt, act);
    chk("zero_lat", lat, 4); chk("zero_cnt", cnt, 0); chk("zero_act", act, 0);
    run(29'h1FFFFFFF, 1'b0, 5'd29, lat, low, cnt, act);
    chk("ones_lat", lat, 4); chk("ones_cnt", cnt, 29); chk("ones_act", act, 1);
    chk("ones_ready_low", low, 5);
    run(29'hF, 1'b1, 5'd0, lat, low, cnt, act);
    chk("approx_cnt", cnt, 0); chk("approx_act", act, 1);
    run(29'hF, 1'b0, 5'd0, lat, low, cnt, act);
    chk("exactF_cnt", cnt, 4); chk("exactF_act", act, 1);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_vec = 29'h15555555; in_approx = 1'b0; in_thresh = 5'd16;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("hold_lat", lat, 4);
    in_valid = 1'b1; in_vec = 29'h7; in_approx = 1'b0; in_thresh = 5'd2;
    for (int i = 0; i < 6; i++) begin
      chk("hold_valid", out_valid, 1); chk("hold_cnt", out_count, 15);
      chk("hold_act", out_act, 0); chk("hold_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_ready", in_ready, 1); chk("post_hs_valid", out_valid, 0);
    @(negedge clk);
    chk("late_accept_busy", busy, 1);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("late_lat", lat, 4); chk("late_cnt", out_count, 3); chk("late_act", out_act, 1);
    @(negedge clk);
    in_valid = 1'b1; in_vec = 29'h1FFFFFFF; in_approx = 1'b0; in_thresh = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0); chk("mid_rst_cnt", out_count, 0);
    chk("mid_rst_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_no_pulse", out_valid, 0);
      @(negedge clk);
    end
    run(29'h1, 1'b0, 5'd1, lat, low, cnt, act);
    chk("after_rst_cnt", cnt, 1); chk("after_rst_act", act, 1);
    for (int r = 0; r < 5; r++) begin
      v = r == 0 ? 29'h1FFFFFFF : 29'($urandom);
      t = 5'($urandom_range(0, 29));
      @(negedge clk);
      sw_valid = 1'b1; sw_vec = v; sw_thr = t;
      @(negedge clk);
      sw_valid = 1'b0; sw_vec = ~v;
      for (int g = 0; g < 3; g++) begin lats[g] = -1; cnts[g] = -1; acts[g] = -1; end
      for (int k = 0; k < 40; k++) begin
        all = 1'b1;
        for (int g = 0; g < 3; g++) begin
          if (sw_ov[g] && lats[g] < 0) begin
            lats[g] = k; cnts[g] = int'(sw_cnt[g]); acts[g] = int'(sw_act[g]);
          end
          if (lats[g] < 0 || !sw_rdy[g]) all = 1'b0;
        end
        if (all) break;
        @(negedge clk);
      end
      for (int g = 0; g < 3; g++) begin
        chk("sweep_lat", lats[g], NBS[g]);
        chk("sweep_cnt", cnts[g], r == 0 ? 29 : $countones(v));
        chk("sweep_act", acts[g], (r == 0 ? 29 : $countones(v)) >= int'(t) ? 1 : 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
